dht11_read_scheduler: RTL and testbench

Sequences measurements on the DHT11 single-wire reader. Merges two request sources: a periodic auto-poll timer and a manual request pulse. Enforces the sensor's minimum spacing between start pulses, times out a missing sensor, checks the checksum and retries failed reads. Publishes one validated result set with valid/error status. Sits between the reader core (drives its start input, consumes its done strobe and 5 data bytes) and downstream consumers (FND/UART).

---
 rtl/dht11_pkg.sv | 25 ++
 rtl/dht11_read_scheduler_if.sv | 36 +++
 rtl/ms_tick_gen.sv | 28 ++
 rtl/dht11_read_scheduler.sv | 189 ++++++++++++++++++
 tb/tb_dht11_read_scheduler.sv | 358 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/dht11_pkg.sv
// Shared types and helpers for the DHT11 read scheduler: FSM states,
// request-source encodings and the frame checksum compare.
package dht11_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_GAP   = 3'd1,
    ST_START = 3'd2,
    ST_WAIT  = 3'd3,
    ST_CHECK = 3'd4,
    ST_FAIL  = 3'd5
  } state_t;

  localparam logic SRC_AUTO   = 1'b0;
  localparam logic SRC_MANUAL = 1'b1;

  function automatic logic checksum_ok(input logic [7:0] hum_int, input logic [7:0] hum_dec,
                                       input logic [7:0] tem_int, input logic [7:0] tem_dec,
                                       input logic [7:0] chk);
    logic [7:0] sum;
    sum = hum_int + hum_dec + tem_int + tem_dec;
    return (sum == chk);
  endfunction

endpackage

// File: rtl/dht11_read_scheduler_if.sv
// Request, reader-side and result signals of the DHT11 read scheduler.
// master = scheduler side, slave = reader core / request sources / consumers.
interface dht11_read_scheduler_if;
  logic       auto_en;
  logic       req;
  logic       rd_start;
  logic       rd_done;
  logic [7:0] rd_hum_int;
  logic [7:0] rd_hum_dec;
  logic [7:0] rd_tem_int;
  logic [7:0] rd_tem_dec;
  logic [7:0] rd_chk;
  logic [7:0] hum_int;
  logic [7:0] hum_dec;
  logic [7:0] tem_int;
  logic [7:0] tem_dec;
  logic       data_valid;
  logic       err;
  logic       busy;
  logic       src;
  logic [1:0] retry_cnt;
  logic [15:0] stat_ok;
  logic [15:0] stat_fail;

  modport master (
    input  auto_en, req, rd_done, rd_hum_int, rd_hum_dec, rd_tem_int, rd_tem_dec, rd_chk,
    output rd_start, hum_int, hum_dec, tem_int, tem_dec, data_valid, err, busy, src,
           retry_cnt, stat_ok, stat_fail
  );

  modport slave (
    output auto_en, req, rd_done, rd_hum_int, rd_hum_dec, rd_tem_int, rd_tem_dec, rd_chk,
    input  rd_start, hum_int, hum_dec, tem_int, tem_dec, data_valid, err, busy, src,
           retry_cnt, stat_ok, stat_fail
  );
endinterface

// File: rtl/ms_tick_gen.sv
// Millisecond tick generator: one-cycle registered pulse every CLK_HZ/1000 cycles.
module ms_tick_gen #(
  parameter int CLK_HZ = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  output logic ms_tick
);
  localparam int DIV = CLK_HZ / 1000;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] div_cnt;

  // Divider counter; tick is registered on the terminal count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      ms_tick <= 1'b0;
    end else if (div_cnt == LAST) begin
      div_cnt <= '0;
      ms_tick <= 1'b1;
    end else begin
      div_cnt <= div_cnt + CW'(1);
      ms_tick <= 1'b0;
    end
  end
endmodule

// File: rtl/dht11_read_scheduler.sv
// DHT11 read scheduler: merges auto-poll and manual requests, spaces start pulses,
// times out, checks and retries reads. Define DHT11_STATS_EN for ok/fail counters.
module dht11_read_scheduler
  import dht11_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int PERIOD_MS  = 5000,
  parameter int MIN_GAP_MS = 2000,
  parameter int TIMEOUT_MS = 30,
  parameter int MAX_RETRY  = 2
) (
  input logic                    clk,
  input logic                    reset,
  dht11_read_scheduler_if.master bus
);
  localparam int GW = $clog2(MIN_GAP_MS + 1);
  localparam int PW = (PERIOD_MS > 1) ? $clog2(PERIOD_MS) : 1;
  localparam int TW = (TIMEOUT_MS > 1) ? $clog2(TIMEOUT_MS) : 1;
  localparam logic [GW-1:0] GAP_MAX     = GW'(MIN_GAP_MS);
  localparam logic [PW-1:0] PERIOD_LAST = PW'(PERIOD_MS - 1);
  localparam logic [TW-1:0] TO_LAST     = TW'(TIMEOUT_MS - 1);
  localparam logic [1:0]    RETRY_MAX   = 2'(MAX_RETRY);

  state_t        state;
  logic          ms_tick;
  logic [GW-1:0] gap_cnt;
  logic [PW-1:0] period_cnt;
  logic [TW-1:0] to_cnt;
  logic          auto_pend;
  logic          man_pend;
  logic          done_q;
  logic          done_rise;
  logic          frame_ok;
  logic          take_man;
  logic          take_auto;

  ms_tick_gen #(.CLK_HZ(CLK_HZ)) u_tick (.clk(clk), .reset(reset), .ms_tick(ms_tick));

  assign done_rise = bus.rd_done & ~done_q;
  assign frame_ok  = checksum_ok(bus.rd_hum_int, bus.rd_hum_dec, bus.rd_tem_int, bus.rd_tem_dec, bus.rd_chk)
                     && ({bus.rd_hum_int, bus.rd_hum_dec, bus.rd_tem_int, bus.rd_tem_dec, bus.rd_chk} != 40'd0);
  assign take_man  = (state == ST_IDLE) && man_pend;
  assign take_auto = (state == ST_IDLE) && !man_pend && auto_pend;

  // Pending-request flags and the auto-poll period counter; a new request beats a clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      man_pend   <= 1'b0;
      auto_pend  <= 1'b0;
      period_cnt <= '0;
    end else begin
      if (bus.req) begin
        man_pend <= 1'b1;
      end else if (take_man) begin
        man_pend <= 1'b0;
      end
      if (!bus.auto_en) begin
        period_cnt <= '0;
        auto_pend  <= 1'b0;
      end else if (ms_tick && (period_cnt == PERIOD_LAST)) begin
        period_cnt <= '0;
        auto_pend  <= 1'b1;
      end else begin
        if (ms_tick) begin
          period_cnt <= period_cnt + PW'(1);
        end
        if (take_auto) begin
          auto_pend <= 1'b0;
        end
      end
    end
  end

  // Milliseconds since the last start pulse; starts at zero so reset also imposes the gap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gap_cnt <= '0;
    end else if (state == ST_START) begin
      gap_cnt <= '0;
    end else if (ms_tick && (gap_cnt < GAP_MAX)) begin
      gap_cnt <= gap_cnt + GW'(1);
    end
  end

  // Measurement sequencer with registered handshake and result outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= ST_IDLE;
      to_cnt         <= '0;
      done_q         <= 1'b0;
      bus.rd_start   <= 1'b0;
      bus.hum_int    <= 8'd0;
      bus.hum_dec    <= 8'd0;
      bus.tem_int    <= 8'd0;
      bus.tem_dec    <= 8'd0;
      bus.data_valid <= 1'b0;
      bus.err        <= 1'b0;
      bus.busy       <= 1'b0;
      bus.src        <= SRC_AUTO;
      bus.retry_cnt  <= 2'd0;
    end else begin
      done_q         <= bus.rd_done;
      bus.rd_start   <= 1'b0;
      bus.data_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (man_pend || auto_pend) begin
            bus.src       <= man_pend ? SRC_MANUAL : SRC_AUTO;
            bus.retry_cnt <= 2'd0;
            bus.busy      <= 1'b1;
            state         <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (gap_cnt >= GAP_MAX) begin
            bus.rd_start <= 1'b1;
            state        <= ST_START;
          end
        end
        ST_START: begin
          to_cnt <= '0;
          state  <= ST_WAIT;
        end
        ST_WAIT: begin
          if (done_rise) begin
            state <= ST_CHECK;
          end else if (ms_tick) begin
            if (to_cnt == TO_LAST) begin
              state <= ST_FAIL;
            end else begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
        end
        ST_CHECK: begin
          if (frame_ok) begin
            bus.hum_int    <= bus.rd_hum_int;
            bus.hum_dec    <= bus.rd_hum_dec;
            bus.tem_int    <= bus.rd_tem_int;
            bus.tem_dec    <= bus.rd_tem_dec;
            bus.data_valid <= 1'b1;
            bus.err        <= 1'b0;
            bus.busy       <= 1'b0;
            state          <= ST_IDLE;
          end else begin
            state <= ST_FAIL;
          end
        end
        ST_FAIL: begin
          if (bus.retry_cnt < RETRY_MAX) begin
            bus.retry_cnt <= bus.retry_cnt + 2'd1;
            state         <= ST_GAP;
          end else begin
            bus.err  <= 1'b1;
            bus.busy <= 1'b0;
            state    <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef DHT11_STATS_EN
  logic ok_event;
  logic fail_event;
  assign ok_event   = (state == ST_CHECK) && frame_ok;
  assign fail_event = (state == ST_FAIL) && (bus.retry_cnt >= RETRY_MAX);

  // Saturating counters of good reads and final failures.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.stat_ok   <= 16'd0;
      bus.stat_fail <= 16'd0;
    end else begin
      if (ok_event && (bus.stat_ok != 16'hFFFF)) begin
        bus.stat_ok <= bus.stat_ok + 16'd1;
      end
      if (fail_event && (bus.stat_fail != 16'hFFFF)) begin
        bus.stat_fail <= bus.stat_fail + 16'd1;
      end
    end
  end
`else
  assign bus.stat_ok   = 16'd0;
  assign bus.stat_fail = 16'd0;
`endif

endmodule

// File: tb/tb_dht11_read_scheduler.sv
// Scoreboard bench for dht11_read_scheduler: a queue-based outcome model predicts each
// request's result; a monitor pops and compares on every completion (busy falling).
module tb_dht11_read_scheduler;
  import dht11_pkg::*;

  localparam int CLK_HZ     = 10_000;
  localparam int PERIOD_MS  = 50;
  localparam int MIN_GAP_MS = 20;
  localparam int TIMEOUT_MS = 5;
  localparam int MAX_RETRY  = 2;
  localparam int CPM        = CLK_HZ / 1000;

  typedef struct packed { logic silent; logic [39:0] frame; } resp_t;
  typedef struct packed { logic ok; logic src; logic [1:0] retries; logic [31:0] data; logic [2:0] starts; } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  dht11_read_scheduler_if bus();

  dht11_read_scheduler #(
    .CLK_HZ(CLK_HZ), .PERIOD_MS(PERIOD_MS), .MIN_GAP_MS(MIN_GAP_MS),
    .TIMEOUT_MS(TIMEOUT_MS), .MAX_RETRY(MAX_RETRY)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int last_start = 0;
  int done_cyc = 0;
  int starts_total = 0;
  int n_ok = 0;
  int n_fail = 0;
  resp_t resp_q[$];
  exp_t  exp_q[$];
  int    start_log[$];
  resp_t plan_att[3];
  logic [31:0] last_good = 32'd0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic check_range(input string name, input int v, input int lo, input int hi);
    checks++;
    if (v < lo || v > hi) begin
      failures++;
      $display("FAIL %s actual=%0d required=[%0d..%0d]", name, v, lo, hi);
    end
  endtask

  // A frame is good when the four data bytes sum (mod 256) to the check byte and it is not all zero.
  function automatic bit frame_good(input logic [39:0] f);
    int s;
    s = int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8]);
    return ((s % 256) == int'(f[7:0])) && (f != 40'd0);
  endfunction

  function automatic resp_t mk(input logic silent, input logic [39:0] frame);
    resp_t r;
    r.silent = silent;
    r.frame  = frame;
    return r;
  endfunction

  function automatic resp_t rand_att();
    int k;
    logic [31:0] d;
    logic [7:0] sum;
    k = $urandom_range(0, 9);
    d = $urandom;
    sum = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    if (k < 2)       return mk(1'b1, 40'd0);
    else if (k == 2) return mk(1'b0, {d, sum + 8'd1});
    else if (k == 3) return mk(1'b0, 40'd0);
    else             return mk(1'b0, {d, sum});
  endfunction

  // Model: attempts are consumed in order until one is good or retries run out.
  task automatic enqueue(input logic src);
    exp_t e;
    int used;
    bit got;
    used = 0;
    got = 1'b0;
    for (int k = 0; k <= MAX_RETRY && !got; k++) begin
      resp_q.push_back(plan_att[k]);
      used++;
      if (!plan_att[k].silent && frame_good(plan_att[k].frame)) got = 1'b1;
    end
    if (got) begin
      last_good = plan_att[used-1].frame[39:8];
      n_ok++;
    end else begin
      n_fail++;
    end
    e.ok = got;
    e.src = src;
    e.retries = 2'(used - 1);
    e.starts = 3'(used);
    e.data = last_good;
    exp_q.push_back(e);
  endtask

  task automatic pulse_req();
    @(negedge clk) bus.req = 1'b1;
    @(negedge clk) bus.req = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic wait_starts(input string name, input int target, input int budget);
    int n;
    n = 0;
    while (starts_total < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, starts_total >= target, 1'b1);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_ctl"}, {bus.rd_start, bus.data_valid, bus.err, bus.busy, bus.src, bus.retry_cnt}, 0);
    check({name, "_data"}, {bus.hum_int, bus.hum_dec, bus.tem_int, bus.tem_dec}, 0);
    check({name, "_stats"}, {bus.stat_ok, bus.stat_fail}, 0);
  endtask

  // Reader responder: serves each start pulse from the planned attempt queue.
  initial begin : responder
    resp_t r;
    bus.rd_done = 1'b0;
    {bus.rd_hum_int, bus.rd_hum_dec, bus.rd_tem_int, bus.rd_tem_dec, bus.rd_chk} = 40'd0;
    forever begin
      @(negedge clk);
      if (!reset && bus.rd_start === 1'b1) begin
        check("start_was_planned", resp_q.size() != 0, 1'b1);
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          if (!r.silent) begin
            repeat (3 * CPM - 1) @(negedge clk);
            {bus.rd_hum_int, bus.rd_hum_dec, bus.rd_tem_int, bus.rd_tem_dec, bus.rd_chk} = r.frame;
            bus.rd_done = 1'b1;
            @(negedge clk);
            bus.rd_done = 1'b0;
          end
        end
      end
    end
  end

  // Monitor: start spacing, data_valid placement, and scoreboard compare on each completion.
  initial begin : monitor
    logic prev_busy;
    int since_starts;
    exp_t e;
    prev_busy = 1'b0;
    since_starts = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_busy = 1'b0;
        since_starts = 0;
        last_start = cyc;
      end else begin
        check("dv_only_at_done", bus.data_valid & ~(prev_busy & ~bus.busy), 1'b0);
        if (bus.rd_start) begin
          check("gap_before_start", (cyc - last_start) >= (MIN_GAP_MS - 1) * CPM, 1'b1);
          last_start = cyc;
          since_starts++;
          starts_total++;
          start_log.push_back(cyc);
        end
        if (prev_busy && !bus.busy) begin
          done_cyc = cyc;
          check("done_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("data_valid", bus.data_valid, e.ok);
            check("err", bus.err, !e.ok);
            check("src", bus.src, e.src);
            check("retry_cnt", bus.retry_cnt, e.retries);
            check("result", {bus.hum_int, bus.hum_dec, bus.tem_int, bus.tem_dec}, e.data);
            check("start_count", since_starts, e.starts);
          end
          since_starts = 0;
        end
        prev_busy = bus.busy;
      end
    end
  end

  initial begin : watchdog
    #(60000 * 10);
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int rel, base, t0, ns;
    bus.auto_en = 1'b0;
    bus.req = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    reset = 1'b0;
    rel = cyc;

    // Single good manual read issued five cycles after reset release.
    repeat (4) @(negedge clk);
    plan_att[0] = mk(1'b0, 40'h37_00_19_05_55);
    enqueue(SRC_MANUAL);
    pulse_req();
    wait_drain("t1_done", 400);
    check("t1_one_start", start_log.size(), 1);
    if (start_log.size() > 0) check_range("t1_first_start", start_log[0] - rel, (MIN_GAP_MS - 1) * CPM, (MIN_GAP_MS + 1) * CPM);
    check("t1_busy_low", bus.busy, 1'b0);

    // Silent sensor: three spaced attempts then sticky error.
    base = start_log.size();
    for (int k = 0; k < 3; k++) plan_att[k] = mk(1'b1, 40'd0);
    enqueue(SRC_MANUAL);
    pulse_req();
    wait_drain("t2_done", 1200);
    check("t2_starts", start_log.size() - base, 3);
    if (start_log.size() >= base + 3) begin
      check_range("t2_retry_gap1", start_log[base+1] - start_log[base], (MIN_GAP_MS - 1) * CPM, (MIN_GAP_MS + 1) * CPM);
      check_range("t2_retry_gap2", start_log[base+2] - start_log[base+1], (MIN_GAP_MS - 1) * CPM, (MIN_GAP_MS + 1) * CPM);
      check_range("t2_timeout", done_cyc - start_log[base+2], (TIMEOUT_MS - 1) * CPM, (TIMEOUT_MS + 1) * CPM + 3);
    end
    repeat (20) @(negedge clk);
    check("t2_err_sticky", {bus.err, bus.busy}, 2'b10);

    // Bad checksum then good; all-zero frame then good.
    plan_att[0] = mk(1'b0, 40'h37_00_19_05_54);
    plan_att[1] = mk(1'b0, 40'h37_00_19_05_55);
    plan_att[2] = mk(1'b1, 40'd0);
    enqueue(SRC_MANUAL);
    pulse_req();
    wait_drain("t3_bad_chk_done", 800);
    plan_att[0] = mk(1'b0, 40'd0);
    plan_att[1] = mk(1'b0, 40'h40_01_1A_02_5D);
    enqueue(SRC_MANUAL);
    pulse_req();
    wait_drain("t3_zero_done", 800);

    // Randomized manual requests.
    for (int t = 0; t < 8; t++) begin
      for (int k = 0; k < 3; k++) plan_att[k] = rand_att();
      enqueue(SRC_MANUAL);
      pulse_req();
      wait_drain("rand_done", 1200);
      repeat ($urandom_range(0, 300)) @(negedge clk);
    end

    // Auto polling at the period, stopped 30 ms into a period.
    repeat (MIN_GAP_MS * CPM) @(negedge clk);
    base = start_log.size();
    for (int r = 0; r < 2; r++) begin
      plan_att[0] = rand_att();
      plan_att[0].silent = 1'b0;
      plan_att[0].frame[7:0] = plan_att[0].frame[39:32] + plan_att[0].frame[31:24] + plan_att[0].frame[23:16] + plan_att[0].frame[15:8] + 8'd0;
      if (plan_att[0].frame == 40'd0) plan_att[0].frame = 40'h01_00_00_00_01;
      enqueue(SRC_AUTO);
    end
    bus.auto_en = 1'b1;
    t0 = cyc;
    wait_drain("t4_done", 1300);
    check("t4_two_polls", start_log.size() - base, 2);
    if (start_log.size() >= base + 2) begin
      check_range("t4_first_poll", start_log[base] - t0, PERIOD_MS * CPM - 12, PERIOD_MS * CPM + 12);
      check_range("t4_period", start_log[base+1] - start_log[base], PERIOD_MS * CPM - 2, PERIOD_MS * CPM + 2);
      while (cyc < start_log[base+1] + 30 * CPM) @(negedge clk);
    end
    bus.auto_en = 1'b0;
    repeat (40 * CPM) @(negedge clk);
    check("t4_no_poll_after_disable", start_log.size() - base, 2);

    // Collapsed manual requests during WAIT while an auto poll becomes pending.
    repeat (MIN_GAP_MS * CPM) @(negedge clk);
    ns = starts_total;
    plan_att[0] = mk(1'b0, 40'h21_03_10_07_3B);
    enqueue(SRC_MANUAL);
    plan_att[0] = mk(1'b0, 40'h22_04_11_08_3F);
    enqueue(SRC_MANUAL);
    plan_att[0] = mk(1'b0, 40'h23_05_12_09_43);
    enqueue(SRC_AUTO);
    bus.auto_en = 1'b1;
    t0 = cyc;
    while (cyc < t0 + PERIOD_MS * CPM - 20) @(negedge clk);
    pulse_req();
    wait_starts("t5_first_start", ns + 1, 50);
    for (int k = 0; k < 3; k++) pulse_req();
    wait_starts("t5_third_start", ns + 3, 1500);
    bus.auto_en = 1'b0;
    wait_drain("t5_done", 400);
    repeat (60 * CPM) @(negedge clk);
    check("t5_total_reads", starts_total - ns, 3);

`ifdef DHT11_STATS_EN
    check("stat_ok", bus.stat_ok, 16'(n_ok));
    check("stat_fail", bus.stat_fail, 16'(n_fail));
`else
    check("stat_ok_tied", bus.stat_ok, 16'd0);
    check("stat_fail_tied", bus.stat_fail, 16'd0);
`endif

    // Reset during WAIT, then a manual request under auto_en must still honour the gap.
    repeat (MIN_GAP_MS * CPM) @(negedge clk);
    ns = starts_total;
    plan_att[0] = mk(1'b0, 40'h30_00_20_00_50);
    enqueue(SRC_MANUAL);
    pulse_req();
    wait_starts("t6_start", ns + 1, 50);
    repeat (10) @(negedge clk);
    bus.auto_en = 1'b1;
    reset = 1'b1;
    #1;
    check_reset_outputs("t6_async_reset");
    exp_q.delete();
    resp_q.delete();
    last_good = 32'd0;
    n_ok = 0;
    n_fail = 0;
    repeat (5) @(negedge clk);
    check_reset_outputs("t6_held_reset");
    reset = 1'b0;
    rel = cyc;
    base = start_log.size();
    plan_att[0] = mk(1'b0, 40'h2A_01_17_03_45);
    enqueue(SRC_MANUAL);
    pulse_req();
    wait_drain("t6_done", 400);
    bus.auto_en = 1'b0;
    check("t6_one_start", start_log.size() - base, 1);
    if (start_log.size() > base) check_range("t6_first_start", start_log[base] - rel, (MIN_GAP_MS - 1) * CPM, (MIN_GAP_MS + 1) * CPM);
`ifdef DHT11_STATS_EN
    check("t6_stat_ok", bus.stat_ok, 16'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
